// File: rtl/pixel_preprocess_pkg.sv
// Shared encodings and default luma weights for the pixel preprocessing stage.
package pixel_preprocess_pkg;

  // Conversion mode; the reserved code behaves as bypass.
  typedef enum logic [1:0] {
    ModeBypass = 2'd0,
    ModeGray   = 2'd1,
    ModeThresh = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  // Frame-level control FSM.
  typedef enum logic [2:0] {
    StReq,
    StWaitFrame,
    StStream,
    StDrain,
    StRelease
  } state_e;

  // 8-bit fixed-point luma weights (sum is 256, so the shift is by 8).
  localparam int unsigned DefWR     = 77;
  localparam int unsigned DefWG     = 150;
  localparam int unsigned DefWB     = 29;
  localparam int unsigned LumaShift = 8;

endpackage

// File: rtl/luma_pipe.sv
// Two-stage luma pipeline: S1 registers the RGB channels, S2 registers the weighted luma
// alongside a delayed copy of the original pixel. Valid travels with the data.
module luma_pipe
  import pixel_preprocess_pkg::*;
#(
  parameter int unsigned CH_BITS = 5,
  parameter int unsigned W_R     = DefWR,
  parameter int unsigned W_G     = DefWG,
  parameter int unsigned W_B     = DefWB
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3*CH_BITS-1:0] rgb_i,
  input  logic                 valid_i,
  output logic [CH_BITS-1:0]   y_o,
  output logic [3*CH_BITS-1:0] rgb_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  localparam int unsigned AccW = CH_BITS + 9;

  logic [CH_BITS-1:0]   r_q, g_q, b_q;
  logic                 s1_valid_q;
  logic [AccW-1:0]      acc;
  logic [CH_BITS-1:0]   y_d, y_q;
  logic [3*CH_BITS-1:0] rgb_q;
  logic                 s2_valid_q;
  logic                 unused_frac;

  // S1: capture the incoming channels when a pixel is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        r_q <= rgb_i[2*CH_BITS +: CH_BITS];
        g_q <= rgb_i[CH_BITS +: CH_BITS];
        b_q <= rgb_i[0 +: CH_BITS];
      end
    end
  end

  // Weighted sum; with weights summing to 256 the top bit stays clear, saturate if it doesn't.
  always_comb begin
    acc = AccW'(r_q) * AccW'(W_R) + AccW'(g_q) * AccW'(W_G) + AccW'(b_q) * AccW'(W_B);
    y_d = acc[AccW-1] ? {CH_BITS{1'b1}} : acc[LumaShift +: CH_BITS];
  end

  // Fractional bits are discarded by the shift.
  assign unused_frac = ^acc[LumaShift-1:0];

  // S2: register luma and the original pixel together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q        <= '0;
      rgb_q      <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q   <= y_d;
        rgb_q <= {r_q, g_q, b_q};
      end
    end
  end

  assign y_o     = y_q;
  assign rgb_o   = rgb_q;
  assign valid_o = s2_valid_q;
  assign busy_o  = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/pixel_preprocess_core.sv
// Per-pixel preprocessing between capture and frame buffer: arbitrates for the buffer, streams
// one frame of DEPTH pixels per grant through a 3-cycle pipeline (bypass / gray / threshold).
module pixel_preprocess_core
  import pixel_preprocess_pkg::*;
#(
  parameter int unsigned CH_BITS   = 5,
  parameter int unsigned DEPTH     = 76800,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH),
  parameter int unsigned W_R       = DefWR,
  parameter int unsigned W_G       = DefWG,
  parameter int unsigned W_B       = DefWB
) (
  input  logic                 px_clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [CH_BITS-1:0]   threshold,
  input  logic [3*CH_BITS-1:0] input_px_data,
  input  logic                 px_valid,
  input  logic                 frame_flag,
  input  logic                 ack_write,
  output logic                 rq_write,
  output logic                 writing,
  output logic                 enable_mem,
  output logic [ADDR_BITS-1:0] write_addr,
  output logic [3*CH_BITS-1:0] output_px_data,
  output logic                 frame_done
);

  localparam int unsigned PixW = 3 * CH_BITS;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [CH_BITS-1:0]   thr_q, thr_d;
  logic [ADDR_BITS-1:0] in_cnt_q, in_cnt_d;
  logic [ADDR_BITS-1:0] out_cnt_q, out_cnt_d;
  logic                 rq_write_q, rq_write_d;
  logic                 writing_q, writing_d;
  logic                 frame_done_q, frame_done_d;
  logic                 enable_mem_q;
  logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
  logic [PixW-1:0]      out_px_q, out_px_d;

  logic                 accept;
  logic                 frame_start;
  logic [CH_BITS-1:0]   pipe_y;
  logic [PixW-1:0]      pipe_rgb;
  logic                 pipe_valid;
  logic                 pipe_busy;

  assign accept      = (state_q == StStream) && px_valid;
  assign frame_start = (state_q == StWaitFrame) && frame_flag;

  luma_pipe #(
    .CH_BITS (CH_BITS),
    .W_R     (W_R),
    .W_G     (W_G),
    .W_B     (W_B)
  ) u_luma_pipe (
    .clk_i   (px_clk),
    .rst_ni  (reset),
    .rgb_i   (input_px_data),
    .valid_i (accept),
    .y_o     (pipe_y),
    .rgb_o   (pipe_rgb),
    .valid_o (pipe_valid),
    .busy_o  (pipe_busy)
  );

  // FSM next state, frame configuration latch and input pixel count.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    thr_d        = thr_q;
    in_cnt_d     = in_cnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StReq: begin
        if (ack_write) state_d = StWaitFrame;
      end
      StWaitFrame: begin
        if (frame_flag) begin
          state_d  = StStream;
          mode_d   = mode_e'(mode);
          thr_d    = threshold;
          in_cnt_d = '0;
        end
      end
      StStream: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == ADDR_BITS'(DEPTH - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Once S1/S2 are empty, the last write is on the outputs this cycle.
        if (!pipe_busy) begin
          state_d      = StRelease;
          frame_done_d = 1'b1;
        end
      end
      StRelease: begin
        if (!ack_write) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
    rq_write_d = (state_d == StReq);
    writing_d  = (state_d == StStream) || (state_d == StDrain);
  end

  // FSM and control output registers.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StReq;
      mode_q       <= ModeBypass;
      thr_q        <= '0;
      in_cnt_q     <= '0;
      rq_write_q   <= 1'b0;
      writing_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      thr_q        <= thr_d;
      in_cnt_q     <= in_cnt_d;
      rq_write_q   <= rq_write_d;
      writing_q    <= writing_d;
      frame_done_q <= frame_done_d;
    end
  end

  // S3: output select and sequential write address; data holds between strobes.
  always_comb begin
    out_px_d     = out_px_q;
    write_addr_d = write_addr_q;
    out_cnt_d    = out_cnt_q;
    if (frame_start) out_cnt_d = '0;
    if (pipe_valid) begin
      write_addr_d = out_cnt_q;
      out_cnt_d    = out_cnt_q + 1'b1;
      unique case (mode_q)
        ModeGray:   out_px_d = {3{pipe_y}};
        ModeThresh: out_px_d = (pipe_y >= thr_q) ? {PixW{1'b1}} : {PixW{1'b0}};
        default:    out_px_d = pipe_rgb;
      endcase
    end
  end

  // S3 registers.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      out_px_q     <= '0;
      write_addr_q <= '0;
      out_cnt_q    <= '0;
      enable_mem_q <= 1'b0;
    end else begin
      out_px_q     <= out_px_d;
      write_addr_q <= write_addr_d;
      out_cnt_q    <= out_cnt_d;
      enable_mem_q <= pipe_valid;
    end
  end

  assign rq_write       = rq_write_q;
  assign writing        = writing_q;
  assign frame_done     = frame_done_q;
  assign enable_mem     = enable_mem_q;
  assign write_addr     = write_addr_q;
  assign output_px_data = out_px_q;

endmodule

// File: tb/tb_pixel_preprocess_core.sv
// Self-checking bench for pixel_preprocess_core with a small frame (DEPTH=16).
module tb_pixel_preprocess_core;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        px_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [1:0]  mode = '0;
  logic [4:0]  threshold = '0;
  logic [14:0] input_px_data = '0;
  logic        px_valid = 1'b0;
  logic        frame_flag = 1'b0;
  logic        ack_write = 1'b0;
  logic        rq_write, writing, enable_mem, frame_done;
  logic [AW-1:0] write_addr;
  logic [14:0] output_px_data;

  pixel_preprocess_core #(
    .CH_BITS   (5),
    .DEPTH     (DEPTH),
    .ADDR_BITS (AW),
    .W_R       (77),
    .W_G       (150),
    .W_B       (29)
  ) dut (
    .px_clk         (px_clk),
    .reset          (reset),
    .mode           (mode),
    .threshold      (threshold),
    .input_px_data  (input_px_data),
    .px_valid       (px_valid),
    .frame_flag     (frame_flag),
    .ack_write      (ack_write),
    .rq_write       (rq_write),
    .writing        (writing),
    .enable_mem     (enable_mem),
    .write_addr     (write_addr),
    .output_px_data (output_px_data),
    .frame_done     (frame_done)
  );

  always #5 px_clk = ~px_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge px_clk) cyc <= cyc + 1;

  // Write monitor, sampled away from the active edge.
  logic [AW-1:0] wr_addr_q[$];
  logic [14:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic          done_writing = 1'b0;

  always @(negedge px_clk) begin
    if (enable_mem) begin
      wr_addr_q.push_back(write_addr);
      wr_data_q.push_back(output_px_data);
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      done_writing <= writing;
    end
  end

  logic [14:0] stim_px[DEPTH];
  logic [14:0] exp_px[DEPTH];

  typedef struct {
    logic [1:0]  m;
    logic [4:0]  thr;
    logic [14:0] px;
    logic [14:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  // Reference: luma from plain integer arithmetic, then the mode rule.
  function automatic logic [14:0] model(input logic [1:0] m, input logic [4:0] thr,
                                        input logic [14:0] px);
    int r, g, b, y;
    logic [4:0] y5;
    r  = int'(px[14:10]);
    g  = int'(px[9:5]);
    b  = int'(px[4:0]);
    y  = (r * 77 + g * 150 + b * 29) / 256;
    y5 = y[4:0];
    if (m == 2'd1) return {y5, y5, y5};
    if (m == 2'd2) return (y >= int'(thr)) ? 15'h7FFF : 15'h0000;
    return px;
  endfunction

  // Runs one granted frame from stim_px; returns monitor base index and first-pixel cycle.
  task automatic run_frame(input logic [1:0] m, input logic [4:0] thr, input bit bubbles,
                           input bit hold_ack, output int base, output int first_cyc);
    int waited = 0;
    int i = 0;
    int d0;
    base      = wr_data_q.size();
    first_cyc = 0;
    d0        = done_cnt;
    while (!rq_write && waited < 40) begin
      step();
      waited++;
    end
    check("rq_write_asserted", 32'(rq_write), 32'd1);
    ack_write = 1'b1;
    step();
    check("rq_write_dropped_on_grant", 32'(rq_write), 32'd0);
    mode       = m;
    threshold  = thr;
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    // Mid-frame config changes must not take effect.
    mode       = 2'($urandom);
    threshold  = 5'($urandom);
    check("writing_at_frame_start", 32'(writing), 32'd1);
    while (i < int'(DEPTH)) begin
      px_valid      = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      input_px_data = px_valid ? stim_px[i] : 15'($urandom);
      if (px_valid && i == 0) first_cyc = cyc;
      step();
      if (px_valid) i++;
    end
    // Pixels beyond DEPTH must be ignored.
    repeat (3) begin
      px_valid      = 1'b1;
      input_px_data = 15'($urandom);
      step();
    end
    px_valid = 1'b0;
    waited   = 0;
    while (done_cnt == d0 && waited < 20) begin
      step();
      waited++;
    end
    step();
    step();
    check("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
    if (!hold_ack) begin
      ack_write = 1'b0;
      step();
    end
  endtask

  task automatic verify(input string tag, input int base, input int first_cyc);
    int n;
    n = wr_data_q.size() - base;
    check($sformatf("%s n_writes", tag), 32'(n), DEPTH);
    for (int i = 0; i < int'(DEPTH) && i < n; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 32'(wr_addr_q[base + i]), 32'(i));
      check($sformatf("%s data[%0d]", tag, i), 32'(wr_data_q[base + i]), 32'(exp_px[i]));
    end
    if (n > 0) begin
      check($sformatf("%s latency", tag), 32'(wr_cyc_q[base] - first_cyc), 32'd3);
      check($sformatf("%s done_after_last", tag), 32'(done_cyc - wr_cyc_q[base + n - 1]),
            32'd1);
      check($sformatf("%s writing_low_at_done", tag), 32'(done_writing), 32'd0);
    end
  endtask

  initial begin
    int base, fc;
    logic [1:0] rm;
    logic [4:0] rt;

    vecs[0]  = '{2'd1, 5'd0,  15'h7FFF, 15'h7FFF};
    vecs[1]  = '{2'd1, 5'd0,  15'h7C00, 15'h2529};
    vecs[2]  = '{2'd2, 5'd16, 15'h03E0, 15'h7FFF};
    vecs[3]  = '{2'd2, 5'd16, 15'h001F, 15'h0000};
    vecs[4]  = '{2'd0, 5'd0,  15'h1234, 15'h1234};
    vecs[5]  = '{2'd3, 5'd7,  15'h4321, 15'h4321};
    vecs[6]  = '{2'd2, 5'd31, 15'h7FFF, 15'h7FFF};
    vecs[7]  = '{2'd2, 5'd9,  15'h7C00, 15'h7FFF};
    vecs[8]  = '{2'd2, 5'd10, 15'h7C00, 15'h0000};
    vecs[9]  = '{2'd1, 5'd0,  15'h03E0, 15'h4A52};
    vecs[10] = '{2'd1, 5'd0,  15'h0000, 15'h0000};
    vecs[11] = '{2'd2, 5'd0,  15'h0000, 15'h7FFF};

    // Reset state.
    #1 reset = 1'b0;
    #1;
    check("reset rq_write", 32'(rq_write), 32'd0);
    check("reset writing", 32'(writing), 32'd0);
    check("reset enable_mem", 32'(enable_mem), 32'd0);
    check("reset addr_data", 32'({write_addr, output_px_data}), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    check("rq_write_before_first_edge", 32'(rq_write), 32'd0);
    step();
    check("rq_write_after_release", 32'(rq_write), 32'd1);

    // Table-driven constant-pixel frames.
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stim_px[i] = vecs[v].px;
        exp_px[i]  = vecs[v].exp;
      end
      run_frame(vecs[v].m, vecs[v].thr, 1'b0, 1'b0, base, fc);
      verify($sformatf("vec%0d", v), base, fc);
    end

    // Randomised frames with bubbles against the reference model.
    for (int f = 0; f < 4; f++) begin
      rm = (f == 0) ? 2'd0 : 2'($urandom);
      rt = 5'($urandom);
      for (int i = 0; i < int'(DEPTH); i++) begin
        stim_px[i] = 15'($urandom);
        exp_px[i]  = model(rm, rt, stim_px[i]);
      end
      run_frame(rm, rt, 1'b1, 1'b0, base, fc);
      verify($sformatf("rand%0d", f), base, fc);
    end

    // Handshake: frame_flag before grant is ignored.
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    step();
    check("hs early_flag writing", 32'(writing), 32'd0);
    check("hs early_flag rq_write", 32'(rq_write), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      stim_px[i] = 15'($urandom);
      exp_px[i]  = stim_px[i];
    end
    run_frame(2'd0, 5'd0, 1'b0, 1'b1, base, fc);
    verify("hs", base, fc);
    repeat (4) step();
    check("hs release_holds rq_write", 32'(rq_write), 32'd0);
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    step();
    check("hs flag_in_release writing", 32'(writing), 32'd0);
    ack_write = 1'b0;
    step();
    check("hs rq_write_reasserts", 32'(rq_write), 32'd1);

    // Reset in the middle of a frame.
    ack_write = 1'b1;
    step();
    mode       = 2'd0;
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      px_valid      = 1'b1;
      input_px_data = 15'h5555;
      step();
    end
    check("mid_reset writes_in_flight", 32'(enable_mem), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset rq_write", 32'(rq_write), 32'd0);
    check("mid_reset writing", 32'(writing), 32'd0);
    check("mid_reset enable_mem", 32'(enable_mem), 32'd0);
    check("mid_reset addr_data", 32'({write_addr, output_px_data}), 32'd0);
    px_valid  = 1'b0;
    ack_write = 1'b0;
    repeat (3) step();
    check("mid_reset no_writes", 32'(enable_mem), 32'd0);
    reset = 1'b1;
    check("mid_reset rq_low_before_edge", 32'(rq_write), 32'd0);
    step();
    check("mid_reset rq_write_next_cycle", 32'(rq_write), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      stim_px[i] = 15'($urandom);
      exp_px[i]  = model(2'd1, 5'd0, stim_px[i]);
    end
    run_frame(2'd1, 5'd0, 1'b1, 1'b0, base, fc);
    verify("post_reset", base, fc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
